// File: rtl/zpu_sd_bridge_if.sv
// Bundle of the ZPU firmware register signals and the hps_io SD block signals.
// The bridge uses the slave view. The environment side (hps_io, ZPU, bench) uses the master view.
interface zpu_sd_bridge_if #(
  parameter int NUM_DRV = 4,
  parameter int BUF_AW  = 9
);
  logic [31:0]         zpu_out2;
  logic [31:0]         zpu_out3;
  logic                zpu_data_wr;
  logic                zpu_data_rd;
  logic                zpu_io_wr;
  logic [15:0]         zpu_in2;
  logic [31:0]         zpu_in3;
  logic [31:0]         sd_lba;
  logic [NUM_DRV-1:0]  sd_rd;
  logic [NUM_DRV-1:0]  sd_wr;
  logic                sd_ack;
  logic [BUF_AW-1:0]   sd_buff_addr;
  logic [7:0]          sd_buff_dout;
  logic                sd_buff_wr;
  logic [7:0]          sd_buff_din;
  logic [NUM_DRV-1:0]  img_mounted;
  logic                img_readonly;
  logic [63:0]         img_size;
  logic [7:0]          ioctl_index;

  modport slave (
    input  zpu_out2, zpu_out3, zpu_data_wr, zpu_data_rd, zpu_io_wr,
    output zpu_in2, zpu_in3, sd_lba, sd_rd, sd_wr,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output sd_buff_din,
    input  img_mounted, img_readonly, img_size, ioctl_index
  );

  modport master (
    output zpu_out2, zpu_out3, zpu_data_wr, zpu_data_rd, zpu_io_wr,
    input  zpu_in2, zpu_in3, sd_lba, sd_rd, sd_wr,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  sd_buff_din,
    output img_mounted, img_readonly, img_size, ioctl_index
  );
endinterface

// File: rtl/zpu_sd_bridge.sv
// Bridge between the ZPU I/O registers and the hps_io SD block interface.
// It holds the sector buffer, the LBA latch, the request FSM with its timeout, and the mount-event queue.
module zpu_sd_bridge #(
  parameter int                 NUM_DRV = 4,
  parameter int                 BUF_AW  = 9,
  parameter logic [23:0]        TIMEOUT = 24'd5000000,
  parameter logic [NUM_DRV-1:0] RO_MASK = {NUM_DRV{1'b0}}
) (
  input  logic               clk_sys,
  input  logic               reset,
  zpu_sd_bridge_if.slave     bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  logic       lba_sel;
  logic [2:0] drv;
  assign lba_sel = bus.zpu_out2[0];
  assign drv     = bus.zpu_out2[5:3];

  logic unused_bits;
  assign unused_bits = ^{bus.zpu_out2[31:7], bus.img_size[63:32], bus.ioctl_index[5:0]};

  logic               wr_d1, wr_d2, rd_d1, ack_d1, mack_d1, blk_rd_d1, blk_wr_d1, inc_pend;
  logic [NUM_DRV-1:0] img_d1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_d1 <= 1'b0; wr_d2 <= 1'b0; rd_d1 <= 1'b0; ack_d1 <= 1'b0; mack_d1 <= 1'b0;
      blk_rd_d1 <= 1'b0; blk_wr_d1 <= 1'b0; img_d1 <= '0;
    end else begin
      wr_d1 <= bus.zpu_data_wr; wr_d2 <= wr_d1; rd_d1 <= bus.zpu_data_rd;
      ack_d1 <= bus.sd_ack; mack_d1 <= bus.zpu_out2[6];
      blk_rd_d1 <= bus.zpu_out2[1]; blk_wr_d1 <= bus.zpu_out2[2]; img_d1 <= bus.img_mounted;
    end
  end

  logic               wr_evt, rd_fall, ack_fall, mack_rise, rd_rise, wr_rise, blk_evt;
  logic [NUM_DRV-1:0] mnt_rise;
  assign wr_evt    = wr_d1 & ~wr_d2;
  assign rd_fall   = rd_d1 & ~bus.zpu_data_rd;
  assign ack_fall  = ack_d1 & ~bus.sd_ack;
  assign mack_rise = bus.zpu_out2[6] & ~mack_d1;
  assign rd_rise   = bus.zpu_out2[1] & ~blk_rd_d1;
  assign wr_rise   = bus.zpu_out2[2] & ~blk_wr_d1;
  assign blk_evt   = rd_rise | wr_rise;
  assign mnt_rise  = bus.img_mounted & ~img_d1;

  // ZPU byte pointer and LBA latch; a buffer write bumps the pointer one cycle after the store
  logic [BUF_AW-1:0] ptr_q;
  logic [31:0]       lba_q;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ptr_q <= '0; lba_q <= '0; inc_pend <= 1'b0;
    end else begin
      inc_pend <= wr_evt & ~lba_sel;
      if (wr_evt && lba_sel) lba_q <= bus.zpu_out3;
      if (bus.zpu_io_wr)              ptr_q <= '0;
      else if (inc_pend || rd_fall)   ptr_q <= ptr_q + BUF_AW'(1);
    end
  end

  logic [7:0] mem [2**BUF_AW];
  logic [7:0] buf_q, din_q;
  always_ff @(posedge clk_sys) begin
    if (wr_evt && !lba_sel) mem[ptr_q] <= bus.zpu_out3[7:0];
    if (bus.sd_buff_wr)     mem[bus.sd_buff_addr] <= bus.sd_buff_dout;
    buf_q <= mem[ptr_q];
    din_q <= mem[bus.sd_buff_addr];
  end

  logic [NUM_DRV-1:0] drv_oh, ent_ro;
  logic               drv_ok, ro_hit, req_ok;
  always_comb begin
    drv_oh = '0;
    for (int i = 0; i < NUM_DRV; i++) drv_oh[i] = (drv == 3'(i));
  end
  assign drv_ok = |drv_oh;
  assign ro_hit = |(drv_oh & ent_ro);
  assign req_ok = drv_ok & (rd_rise | ~ro_hit);

  state_t             state_q, state_d;
  logic [NUM_DRV-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic               io_done_q, io_done_d, io_err_q, io_err_d;
  logic [23:0]        timer_q, timer_d;
  logic               tmo;
  assign tmo = (timer_q == TIMEOUT - 24'd1);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE; sd_rd_q <= '0; sd_wr_q <= '0;
      io_done_q <= 1'b0; io_err_q <= 1'b0; timer_q <= '0;
    end else begin
      state_q <= state_d; sd_rd_q <= sd_rd_d; sd_wr_q <= sd_wr_d;
      io_done_q <= io_done_d; io_err_q <= io_err_d; timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (blk_evt && req_ok) state_d = S_REQ;
      S_REQ:   if (bus.sd_ack) state_d = S_XFER; else if (tmo) state_d = S_IDLE;
      S_XFER:  if (ack_fall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_d = sd_rd_q; sd_wr_d = sd_wr_q;
    io_done_d = io_done_q; io_err_d = io_err_q; timer_d = timer_q;
    case (state_q)
      S_IDLE: if (blk_evt) begin
        if (req_ok) begin
          io_done_d = 1'b0; io_err_d = 1'b0; timer_d = '0;
          sd_rd_d = rd_rise ? drv_oh : '0;
          sd_wr_d = rd_rise ? '0 : drv_oh;
        end else begin
          io_done_d = 1'b1; io_err_d = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.sd_ack) begin
          sd_rd_d = '0; sd_wr_d = '0;
        end else if (tmo) begin
          sd_rd_d = '0; sd_wr_d = '0; io_done_d = 1'b1; io_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_XFER: if (ack_fall) io_done_d = 1'b1;
      default: ;
    endcase
  end

  // Mount queue: per-drive entries, lowest pending drive reported first
  logic [NUM_DRV-1:0] pend, sel_oh;
  logic [31:0]        ent_size [NUM_DRV];
  logic [1:0]         ent_type [NUM_DRV];
  logic [2:0]         sel_idx, rep_fileno;
  logic [31:0]        sel_size, rep_size;
  logic [1:0]         sel_type, rep_type;
  logic               sel_ro, rep_ro, reported, toggle, rep_go;

  always_comb begin
    sel_idx = '0; sel_oh = '0; sel_size = '0; sel_type = '0; sel_ro = 1'b0;
    for (int i = NUM_DRV - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_idx = 3'(i); sel_oh = '0; sel_oh[i] = 1'b1;
        sel_size = ent_size[i]; sel_type = ent_type[i]; sel_ro = ent_ro[i];
      end
    end
  end
  assign rep_go = ~reported & (|pend);

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NUM_DRV; i++) begin
      if (mnt_rise[i]) begin
        ent_size[i] <= bus.img_size[31:0];
        ent_type[i] <= bus.ioctl_index[7:6];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend <= '0; ent_ro <= RO_MASK; reported <= 1'b0; toggle <= 1'b0;
      rep_fileno <= '0; rep_type <= '0; rep_ro <= 1'b0; rep_size <= '0;
    end else begin
      pend <= (pend & ~(rep_go ? sel_oh : '0)) | mnt_rise;
      for (int i = 0; i < NUM_DRV; i++)
        if (mnt_rise[i]) ent_ro[i] <= bus.img_readonly | RO_MASK[i];
      if (mack_rise) reported <= 1'b0;
      if (rep_go) begin
        reported <= 1'b1; toggle <= ~toggle; rep_fileno <= sel_idx;
        rep_type <= sel_type; rep_ro <= sel_ro; rep_size <= sel_size;
      end
    end
  end

  assign bus.sd_lba      = lba_q;
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.sd_buff_din = din_q;
  assign bus.zpu_in3     = lba_sel ? rep_size : {24'b0, buf_q};
  assign bus.zpu_in2     = {6'b0, |pend, io_err_q, rep_ro, rep_type, rep_fileno, toggle, io_done_q};
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed bench for zpu_sd_bridge: LBA/read request, buffer round trip, errors, timeout, mount queue, reset.
module tb_zpu_sd_bridge;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  zpu_sd_bridge_if #(.NUM_DRV(4), .BUF_AW(9)) bus ();

  zpu_sd_bridge #(.NUM_DRV(4), .BUF_AW(9), .TIMEOUT(24'd100), .RO_MASK(4'b0100)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic lba, input logic [31:0] val);
    bus.zpu_out2 = {31'b0, lba};
    bus.zpu_out3 = val;
    bus.zpu_data_wr = 1'b1;
    repeat (3) tick();
    bus.zpu_data_wr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic io_wr_pulse();
    bus.zpu_io_wr = 1'b1; tick(); bus.zpu_io_wr = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b);
    tick();
    b = bus.zpu_in3[7:0];
    bus.zpu_data_rd = 1'b1; tick();
    bus.zpu_data_rd = 1'b0; tick();
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.sd_rd !== 4'b0) begin n_err++; $display("FAIL reset_sd_rd got %b want 0000", bus.sd_rd); end
    n_cmp++; if (bus.sd_wr !== 4'b0) begin n_err++; $display("FAIL reset_sd_wr got %b want 0000", bus.sd_wr); end
    n_cmp++; if (bus.sd_lba !== 32'h0) begin n_err++; $display("FAIL reset_sd_lba got %h want 0", bus.sd_lba); end
    n_cmp++; if (bus.zpu_in2 !== 16'h0) begin n_err++; $display("FAIL reset_in2 got %h want 0", bus.zpu_in2); end
  endtask

  task automatic test_lba_read();
    logic [7:0] b;
    write_word(1'b1, 32'h0000_1234);
    n_cmp++; if (bus.sd_lba !== 32'h1234) begin n_err++; $display("FAIL lba_latch got %h want 1234", bus.sd_lba); end
    bus.zpu_out2 = 32'h0A;
    tick();
    n_cmp++; if (bus.sd_rd !== 4'b0010) begin n_err++; $display("FAIL rd_req got %b want 0010", bus.sd_rd); end
    n_cmp++; if (bus.zpu_in2[0] !== 1'b0) begin n_err++; $display("FAIL rd_busy_done got %b want 0", bus.zpu_in2[0]); end
    repeat (5) tick();
    n_cmp++; if (bus.sd_rd !== 4'b0010) begin n_err++; $display("FAIL rd_hold got %b want 0010", bus.sd_rd); end
    bus.sd_ack = 1'b1; tick();
    n_cmp++; if (bus.sd_rd !== 4'b0) begin n_err++; $display("FAIL rd_ack_clr got %b want 0000", bus.sd_rd); end
    for (int i = 0; i < 3; i++) begin
      bus.sd_buff_addr = 9'(i); bus.sd_buff_dout = 8'(8'h10 + i); bus.sd_buff_wr = 1'b1; tick();
    end
    bus.sd_buff_wr = 1'b0;
    n_cmp++; if (bus.zpu_in2[0] !== 1'b0) begin n_err++; $display("FAIL xfer_done_early got %b want 0", bus.zpu_in2[0]); end
    bus.sd_ack = 1'b0; tick();
    n_cmp++; if (bus.zpu_in2[0] !== 1'b1) begin n_err++; $display("FAIL rd_done got %b want 1", bus.zpu_in2[0]); end
    n_cmp++; if (bus.zpu_in2[8] !== 1'b0) begin n_err++; $display("FAIL rd_err got %b want 0", bus.zpu_in2[8]); end
    bus.zpu_out2 = 32'h0;
    io_wr_pulse();
    for (int i = 0; i < 3; i++) begin
      read_byte(b);
      n_cmp++; if (b !== 8'(8'h10 + i)) begin n_err++; $display("FAIL hps_wr_byte%0d got %h want %h", i, b, 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_buffer();
    logic [7:0] b, exp;
    io_wr_pulse();
    for (int i = 0; i < 512; i++) write_word(1'b0, 32'(i & 255));
    write_word(1'b0, 32'h5A);
    io_wr_pulse();
    read_byte(b);
    n_cmp++; if (b !== 8'h5A) begin n_err++; $display("FAIL ptr_wrap got %h want 5a", b); end
    read_byte(b);
    n_cmp++; if (b !== 8'h01) begin n_err++; $display("FAIL zpu_rd_byte1 got %h want 01", b); end
    bus.zpu_out2 = 32'h04;
    tick();
    n_cmp++; if (bus.sd_wr !== 4'b0001) begin n_err++; $display("FAIL wr_req got %b want 0001", bus.sd_wr); end
    n_cmp++; if (bus.sd_rd !== 4'b0) begin n_err++; $display("FAIL wr_req_rd got %b want 0000", bus.sd_rd); end
    bus.sd_ack = 1'b1; tick();
    n_cmp++; if (bus.sd_wr !== 4'b0) begin n_err++; $display("FAIL wr_ack_clr got %b want 0000", bus.sd_wr); end
    for (int i = 0; i < 512; i++) begin
      bus.sd_buff_addr = 9'(i); tick();
      exp = (i == 0) ? 8'h5A : 8'(i & 255);
      n_cmp++; if (bus.sd_buff_din !== exp) begin n_err++; $display("FAIL buf_din addr %0d got %h want %h", i, bus.sd_buff_din, exp); end
    end
    bus.sd_ack = 1'b0; tick();
    n_cmp++; if (bus.zpu_in2[0] !== 1'b1) begin n_err++; $display("FAIL wr_done got %b want 1", bus.zpu_in2[0]); end
    bus.zpu_out2 = 32'h0; tick();
  endtask

  task automatic test_bad_drive();
    bus.zpu_out2 = 32'h2A;
    tick();
    n_cmp++; if (bus.sd_rd !== 4'b0) begin n_err++; $display("FAIL bad_drv_rd got %b want 0000", bus.sd_rd); end
    n_cmp++; if (bus.zpu_in2[0] !== 1'b1) begin n_err++; $display("FAIL bad_drv_done got %b want 1", bus.zpu_in2[0]); end
    n_cmp++; if (bus.zpu_in2[8] !== 1'b1) begin n_err++; $display("FAIL bad_drv_err got %b want 1", bus.zpu_in2[8]); end
    bus.zpu_out2 = 32'h0; tick();
  endtask

  task automatic test_timeout();
    bus.zpu_out2 = 32'h1A;
    tick();
    n_cmp++; if (bus.sd_rd !== 4'b1000) begin n_err++; $display("FAIL tmo_req got %b want 1000", bus.sd_rd); end
    n_cmp++; if (bus.zpu_in2[8] !== 1'b0) begin n_err++; $display("FAIL tmo_err_clr got %b want 0", bus.zpu_in2[8]); end
    n_cmp++; if (bus.zpu_in2[0] !== 1'b0) begin n_err++; $display("FAIL tmo_done_clr got %b want 0", bus.zpu_in2[0]); end
    repeat (99) tick();
    n_cmp++; if (bus.sd_rd !== 4'b1000) begin n_err++; $display("FAIL tmo_early got %b want 1000", bus.sd_rd); end
    tick();
    n_cmp++; if (bus.sd_rd !== 4'b0) begin n_err++; $display("FAIL tmo_clr got %b want 0000", bus.sd_rd); end
    n_cmp++; if (bus.zpu_in2[8] !== 1'b1) begin n_err++; $display("FAIL tmo_err got %b want 1", bus.zpu_in2[8]); end
    n_cmp++; if (bus.zpu_in2[0] !== 1'b1) begin n_err++; $display("FAIL tmo_done got %b want 1", bus.zpu_in2[0]); end
    bus.zpu_out2 = 32'h0; tick();
  endtask

  task automatic test_mount_queue();
    bus.img_size = 64'h0000_0000_0001_2000; bus.img_readonly = 1'b1; bus.ioctl_index = 8'h80;
    bus.img_mounted = 4'b0101; tick(); bus.img_mounted = 4'b0;
    n_cmp++; if (bus.zpu_in2[9] !== 1'b1) begin n_err++; $display("FAIL mnt_pend_set got %b want 1", bus.zpu_in2[9]); end
    n_cmp++; if (bus.zpu_in2[1] !== 1'b0) begin n_err++; $display("FAIL mnt_tgl_early got %b want 0", bus.zpu_in2[1]); end
    tick();
    n_cmp++; if (bus.zpu_in2[4:2] !== 3'd0) begin n_err++; $display("FAIL mnt_first_fileno got %0d want 0", bus.zpu_in2[4:2]); end
    n_cmp++; if (bus.zpu_in2[1] !== 1'b1) begin n_err++; $display("FAIL mnt_tgl1 got %b want 1", bus.zpu_in2[1]); end
    n_cmp++; if (bus.zpu_in2[9] !== 1'b1) begin n_err++; $display("FAIL mnt_pend_left got %b want 1", bus.zpu_in2[9]); end
    n_cmp++; if (bus.zpu_in2[6:5] !== 2'd2) begin n_err++; $display("FAIL mnt_ftype got %0d want 2", bus.zpu_in2[6:5]); end
    n_cmp++; if (bus.zpu_in2[7] !== 1'b1) begin n_err++; $display("FAIL mnt_ro got %b want 1", bus.zpu_in2[7]); end
    bus.zpu_out2 = 32'h01; #1;
    n_cmp++; if (bus.zpu_in3 !== 32'h0001_2000) begin n_err++; $display("FAIL mnt_size got %h want 00012000", bus.zpu_in3); end
    bus.zpu_out2 = 32'h41; tick();
    n_cmp++; if (bus.zpu_in2[4:2] !== 3'd0) begin n_err++; $display("FAIL mnt_ack_hold got %0d want 0", bus.zpu_in2[4:2]); end
    tick();
    n_cmp++; if (bus.zpu_in2[4:2] !== 3'd2) begin n_err++; $display("FAIL mnt_second_fileno got %0d want 2", bus.zpu_in2[4:2]); end
    n_cmp++; if (bus.zpu_in2[1] !== 1'b0) begin n_err++; $display("FAIL mnt_tgl2 got %b want 0", bus.zpu_in2[1]); end
    n_cmp++; if (bus.zpu_in2[9] !== 1'b0) begin n_err++; $display("FAIL mnt_pend_empty got %b want 0", bus.zpu_in2[9]); end
    bus.zpu_out2 = 32'h0; tick();
  endtask

  task automatic test_ro_mask();
    bus.img_size = 64'h0000_0000_0000_0B00; bus.img_readonly = 1'b0; bus.ioctl_index = 8'h40;
    bus.img_mounted = 4'b0100; tick(); bus.img_mounted = 4'b0;
    bus.zpu_out2 = 32'h40; tick(); tick();
    n_cmp++; if (bus.zpu_in2[4:2] !== 3'd2) begin n_err++; $display("FAIL ro_fileno got %0d want 2", bus.zpu_in2[4:2]); end
    n_cmp++; if (bus.zpu_in2[7] !== 1'b1) begin n_err++; $display("FAIL ro_forced got %b want 1", bus.zpu_in2[7]); end
    n_cmp++; if (bus.zpu_in2[6:5] !== 2'd1) begin n_err++; $display("FAIL ro_ftype got %0d want 1", bus.zpu_in2[6:5]); end
    bus.zpu_out2 = 32'h01; #1;
    n_cmp++; if (bus.zpu_in3 !== 32'h0000_0B00) begin n_err++; $display("FAIL ro_size got %h want 00000b00", bus.zpu_in3); end
    bus.zpu_out2 = 32'h0; tick();
    bus.zpu_out2 = 32'h12; tick();
    n_cmp++; if (bus.sd_rd !== 4'b0100) begin n_err++; $display("FAIL ro_read_ok got %b want 0100", bus.sd_rd); end
    n_cmp++; if (bus.zpu_in2[8] !== 1'b0) begin n_err++; $display("FAIL ro_read_err got %b want 0", bus.zpu_in2[8]); end
    bus.sd_ack = 1'b1; tick(); bus.sd_ack = 1'b0; tick();
    bus.zpu_out2 = 32'h0; tick();
    bus.zpu_out2 = 32'h14; tick();
    n_cmp++; if (bus.sd_wr !== 4'b0) begin n_err++; $display("FAIL ro_wr_blocked got %b want 0000", bus.sd_wr); end
    n_cmp++; if (bus.zpu_in2[8] !== 1'b1) begin n_err++; $display("FAIL ro_wr_err got %b want 1", bus.zpu_in2[8]); end
    n_cmp++; if (bus.zpu_in2[0] !== 1'b1) begin n_err++; $display("FAIL ro_wr_done got %b want 1", bus.zpu_in2[0]); end
    bus.zpu_out2 = 32'h0; tick();
  endtask

  task automatic test_reset_mid();
    bus.zpu_out2 = 32'h02; tick();
    n_cmp++; if (bus.sd_rd !== 4'b0001) begin n_err++; $display("FAIL mid_req got %b want 0001", bus.sd_rd); end
    reset = 1'b1; bus.zpu_out2 = 32'h0; tick();
    n_cmp++; if (bus.sd_rd !== 4'b0) begin n_err++; $display("FAIL mid_rst_rd got %b want 0000", bus.sd_rd); end
    reset = 1'b0; tick();
    bus.zpu_out2 = 32'h02; tick();
    bus.sd_ack = 1'b1; tick();
    reset = 1'b1; bus.zpu_out2 = 32'h0; tick();
    n_cmp++; if (bus.zpu_in2 !== 16'h0) begin n_err++; $display("FAIL mid_rst_in2 got %h want 0", bus.zpu_in2); end
    n_cmp++; if (bus.sd_lba !== 32'h0) begin n_err++; $display("FAIL mid_rst_lba got %h want 0", bus.sd_lba); end
    reset = 1'b0; bus.sd_ack = 1'b0; tick();
    n_cmp++; if (bus.zpu_in2[0] !== 1'b0) begin n_err++; $display("FAIL mid_rst_done got %b want 0", bus.zpu_in2[0]); end
  endtask

  initial begin
    reset = 1'b1;
    bus.zpu_out2 = '0; bus.zpu_out3 = '0; bus.zpu_data_wr = 1'b0; bus.zpu_data_rd = 1'b0;
    bus.zpu_io_wr = 1'b0; bus.sd_ack = 1'b0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0;
    bus.sd_buff_wr = 1'b0; bus.img_mounted = '0; bus.img_readonly = 1'b0; bus.img_size = '0;
    bus.ioctl_index = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_lba_read();
    test_buffer();
    test_bad_drive();
    test_timeout();
    test_mount_queue();
    test_ro_mask();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
